// File: rtl/jogo_pkg.sv
// Shared definitions for the game datapath: state encoding (also used by the
// db_estado debug decode), default timing and the LED/button width.
package jogo_pkg;

  localparam int LARGURA           = 4;
  localparam int T_ACESO_PADRAO    = 50;
  localparam int T_APAGADO_PADRAO  = 25;

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    PAUSA   = 4'd1,
    CARREGA = 4'd2,
    ACESO   = 4'd3,
    APAGADO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  // Width needed to hold a count of 0..n.
  function automatic int largura_contador(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Bundle between the control unit / sequence memory (master) and the
// sequence display block (slave).
// Handshake: the master raises iniciar for at least one cycle while the slave
// is idle (exibindo=0); the slave answers with a single-cycle pronto once the
// whole sequence has been shown. parar aborts a run with no pronto.
// dado_mem is an asynchronous read of endereco, valid in the same cycle.
interface exibe_sequencia_if;
  import jogo_pkg::*;

  logic               iniciar;
  logic               parar;
  logic [LARGURA-1:0] rodada;
  logic [LARGURA-1:0] dado_mem;
  logic [LARGURA-1:0] endereco;
  logic [LARGURA-1:0] leds;
  logic               exibindo;
  logic               pronto;
  logic [3:0]         db_estado;

  modport master (
    output iniciar, parar, rodada, dado_mem,
    input  endereco, leds, exibindo, pronto, db_estado
  );

  modport slave (
    input  iniciar, parar, rodada, dado_mem,
    output endereco, leds, exibindo, pronto, db_estado
  );

endinterface

// File: rtl/exibe_sequencia_contador.sv
// contador_tempo: cycle counter for the lit/dark intervals. Counts while
// enable is high, flags fim at M-1 and wraps to 0; clear takes priority.
module contador_tempo
  import jogo_pkg::*;
#(
  parameter int M = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int W = largura_contador(M);

  logic [W-1:0] r_contagem;
  logic         w_fim;

  assign w_fim = (r_contagem == W'(M - 1));
  assign fim   = w_fim;

  // Count up while enabled, wrap after the last cycle of the interval.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (clear) begin
      r_contagem <= '0;
    end else if (enable) begin
      r_contagem <= w_fim ? '0 : r_contagem + W'(1);
    end
  end

endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays memory entries 0..rodada on the LEDs, each lit for
// T_ACESO cycles followed by T_APAGADO dark cycles, then pulses pronto.
// Optional feature: define ATRASO_INICIAL_EN to insert a dark PAUSA of
// T_APAGADO cycles before the first entry.
module exibe_sequencia
  import jogo_pkg::*;
#(
  parameter int T_ACESO   = T_ACESO_PADRAO,
  parameter int T_APAGADO = T_APAGADO_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  exibe_sequencia_if.slave  bus
);

  estado_t            r_estado;
  logic [LARGURA-1:0] r_limite;
  logic [LARGURA-1:0] r_endereco;
  logic [LARGURA-1:0] r_leds;
  logic               r_exibindo;
  logic               r_pronto;

  logic w_fim_aceso;
  logic w_fim_apagado;
  logic w_conta_aceso;
  logic w_conta_apagado;

  // Each timer only runs in its own state and is held at zero elsewhere,
  // so it always starts from zero when that state is entered.
  assign w_conta_aceso   = (r_estado == ACESO);
  assign w_conta_apagado = (r_estado == APAGADO) || (r_estado == PAUSA);

  contador_tempo #(.M(T_ACESO)) u_tempo_aceso (
    .clock  (clock),
    .reset  (reset),
    .clear  (!w_conta_aceso),
    .enable (w_conta_aceso),
    .fim    (w_fim_aceso)
  );

  contador_tempo #(.M(T_APAGADO)) u_tempo_apagado (
    .clock  (clock),
    .reset  (reset),
    .clear  (!w_conta_apagado),
    .enable (w_conta_apagado),
    .fim    (w_fim_apagado)
  );

  // Sequencer FSM: all outputs are registered alongside the state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_limite   <= '0;
      r_endereco <= '0;
      r_leds     <= '0;
      r_exibindo <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      if (bus.parar && (r_estado != OCIOSO)) begin
        r_estado   <= OCIOSO;
        r_leds     <= '0;
        r_exibindo <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (bus.iniciar && !bus.parar) begin
              r_limite   <= bus.rodada;
              r_endereco <= '0;
              r_exibindo <= 1'b1;
`ifdef ATRASO_INICIAL_EN
              r_estado   <= PAUSA;
`else
              r_estado   <= CARREGA;
`endif
            end
          end
          PAUSA: begin
            if (w_fim_apagado) begin
              r_estado <= CARREGA;
            end
          end
          CARREGA: begin
            r_leds   <= bus.dado_mem;
            r_estado <= ACESO;
          end
          ACESO: begin
            if (w_fim_aceso) begin
              r_leds   <= '0;
              r_estado <= APAGADO;
            end
          end
          APAGADO: begin
            if (w_fim_apagado) begin
              if (r_endereco == r_limite) begin
                r_exibindo <= 1'b0;
                r_pronto   <= 1'b1;
                r_estado   <= FIM;
              end else begin
                r_endereco <= r_endereco + 4'd1;
                r_estado   <= CARREGA;
              end
            end
          end
          FIM: begin
            r_estado <= OCIOSO;
          end
          default: begin
            r_estado   <= OCIOSO;
            r_leds     <= '0;
            r_exibindo <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.endereco  = r_endereco;
  assign bus.leds      = r_leds;
  assign bus.exibindo  = r_exibindo;
  assign bus.pronto    = r_pronto;
  assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ACESO=4, T_APAGADO=2.
// Honours ATRASO_INICIAL_EN when the build defines it.
module tb_exibe_sequencia;
  import jogo_pkg::*;

  localparam int TA  = 4;
  localparam int TP  = 2;
  localparam int PER = 1 + TA + TP;
`ifdef ATRASO_INICIAL_EN
  localparam int OFF = TP;
`else
  localparam int OFF = 0;
`endif

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [3:0] mem [16];

  exibe_sequencia_if bus ();

  exibe_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and asynchronous memory read.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  assign bus.dado_mem = mem[bus.endereco];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] el, input logic ee,
                         input logic [3:0] ea, input logic ep);
    chk({tag, " leds"},     32'(bus.leds),     32'(el));
    chk({tag, " exibindo"}, 32'(bus.exibindo), 32'(ee));
    chk({tag, " endereco"}, 32'(bus.endereco), 32'(ea));
    chk({tag, " pronto"},   32'(bus.pronto),   32'(ep));
  endtask

  // Pulse iniciar for one edge, then check every cycle against the timing
  // model. stop_at>0 returns after sampling that cycle (for aborts).
  task automatic run_seq(input logic [3:0] rod, input int stop_at, input bit repulse);
    int total;
    int k, e, p;
    logic [3:0] el, ea;
    logic ee, ep;
    total = OFF + PER * (int'(rod) + 1) + 1;
    @(negedge clock);
    bus.rodada  = rod;
    bus.iniciar = 1'b1;
    @(posedge clock);
    #1 bus.iniciar = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      if (c <= OFF) begin
        el = 4'd0; ee = 1'b1; ea = 4'd0; ep = 1'b0;
      end else begin
        k = c - OFF - 1;
        e = k / PER;
        p = k % PER;
        if (e > int'(rod)) begin
          el = 4'd0; ee = 1'b0; ea = rod; ep = 1'b1;
        end else begin
          ea = 4'(e);
          ee = 1'b1;
          ep = 1'b0;
          el = (p >= 1 && p <= TA) ? 4'(1 << (e % 4)) : 4'd0;
        end
      end
      chk_out($sformatf("r%0d c%0d", rod, c), el, ee, ea, ep);
      if (repulse && c == 10) begin
        bus.iniciar = 1'b1;
        bus.rodada  = 4'd0;
      end
      if (repulse && c == 11) bus.iniciar = 1'b0;
      if (stop_at != 0 && c == stop_at) return;
    end
    @(negedge clock);
    chk_out($sformatf("r%0d idle", rod), 4'd0, 1'b0, rod, 1'b0);
    chk($sformatf("r%0d estado", rod), 32'(bus.db_estado), 32'(OCIOSO));
  endtask

  task automatic idle_chk(input string tag, input int n, input logic [3:0] ea);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk_out($sformatf("%s i%0d", tag, i), 4'd0, 1'b0, ea, 1'b0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int a = 0; a < 16; a++) mem[a] = 4'(1 << (a % 4));
    bus.iniciar = 1'b0;
    bus.parar   = 1'b0;
    bus.rodada  = 4'd0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Test 1: idle after reset
    chk("reset estado", 32'(bus.db_estado), 32'(OCIOSO));
    idle_chk("t1", 10, 4'd0);

    // Test 2: single entry
    run_seq(4'd0, 0, 1'b0);

    // Test 3: four entries, iniciar/rodada disturbed mid-run
    run_seq(4'd3, 0, 1'b1);

    // Test 4: full 16-entry sequence, address must stop at 15
    run_seq(4'd15, 0, 1'b0);
    idle_chk("t4 hold", 3, 4'd15);

    // Test 5: abort during the 2nd lit entry
    run_seq(4'd3, 10, 1'b0);
    bus.parar = 1'b1;
    @(negedge clock);
    chk_out("t5 parar", 4'd0, 1'b0, 4'd1, 1'b0);
    chk("t5 estado", 32'(bus.db_estado), 32'(OCIOSO));
    bus.parar = 1'b0;
    idle_chk("t5 idle", 8, 4'd1);
    // parar wins over iniciar while idle
    bus.parar   = 1'b1;
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.parar   = 1'b0;
    bus.iniciar = 1'b0;
    chk("t5 both estado", 32'(bus.db_estado), 32'(OCIOSO));
    idle_chk("t5 both", 3, 4'd1);
    run_seq(4'd0, 0, 1'b0);

    // Test 6: async reset in the dark phase of entry 1 (cycle 13)
    run_seq(4'd1, OFF + 13, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("t6 async", 4'd0, 1'b0, 4'd0, 1'b0);
    chk("t6 estado", 32'(bus.db_estado), 32'(OCIOSO));
    @(negedge clock);
    reset = 1'b0;
    idle_chk("t6 after", 20, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
